avm_word_copier: RTL and testbench

- Avalon-MM master (initiator) that copies a block of 32-bit words from a source address range to a destination address range.
- Drives the same slave protocol the NIOSsoc on-chip memories and peripherals respond to: address, read, write, byteenable, waitrequest, readdatavalid.
- Started by a simple command port from a control FSM or CSR block.
- Exactly one outstanding transaction at a time: read one word, write it, repeat.

---
 rtl/avm_word_copier.sv | 155 +++++++++++++++
 tb/tb_avm_word_copier.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avm_word_copier.sv
// Avalon-MM master that copies len 32-bit words from src_addr to dst_addr, one transaction at a time.
// Optional checksum output enabled by defining AVM_WORD_COPIER_CHECKSUM_EN.
module avm_word_copier #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [LEN_W-1:0]    len,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid
`ifdef AVM_WORD_COPIER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]   checksum
`endif
);

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        FIN
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  src_q, dst_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               start_go;
    logic               rd_capture;
    logic               wr_accept;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        avm_read    = 1'b0;
        avm_write   = 1'b0;
        avm_address = '0;
        start_go    = 1'b0;
        rd_capture  = 1'b0;
        wr_accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_go = 1'b1;
                    state_d  = (len != '0) ? RD_REQ : FIN;
                end
            end
            RD_REQ: begin
                avm_read    = 1'b1;
                avm_address = src_q;
                if (!avm_waitrequest) begin
                    // A zero-latency slave returns data in the acceptance cycle.
                    if (avm_readdatavalid) begin
                        rd_capture = 1'b1;
                        state_d    = WR_REQ;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    rd_capture = 1'b1;
                    state_d    = WR_REQ;
                end
            end
            WR_REQ: begin
                avm_write   = 1'b1;
                avm_address = dst_q;
                if (!avm_waitrequest) begin
                    wr_accept = 1'b1;
                    state_d   = (cnt_q == LEN_W'(1)) ? FIN : RD_REQ;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
        end else begin
            if (start_go && (len != '0)) begin
                src_q <= src_addr;
                dst_q <= dst_addr;
                cnt_q <= len;
            end
            if (rd_capture) begin
                wdata_q <= avm_readdata;
            end
            if (wr_accept) begin
                src_q <= src_q + STRIDE;
                dst_q <= dst_q + STRIDE;
                cnt_q <= cnt_q - LEN_W'(1);
            end
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == FIN);
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = '1;

`ifdef AVM_WORD_COPIER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else if (start_go) begin
            csum_q <= '0;
        end else if (wr_accept) begin
            csum_q <= csum_q ^ wdata_q;
        end
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_avm_word_copier.sv
// Self-checking bench for avm_word_copier: table-driven copies plus stall, ignored-start,
// reset-abort and zero-latency/wrap sequences against a behavioural Avalon-MM memory.
module tb_avm_word_copier;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len;
    logic        busy, done;
    logic [31:0] avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
`ifdef AVM_WORD_COPIER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    avm_word_copier dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .src_addr          (src_addr),
        .dst_addr          (dst_addr),
        .len               (len),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
`ifdef AVM_WORD_COPIER_CHECKSUM_EN
        ,
        .checksum          (checksum)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- slave memory model ----------------
    logic [31:0] mem [64];
    logic [31:0] exp_mem [64];
    logic        reinit = 1'b0;
    logic        zero_lat = 1'b0;
    int          st_rd_idx = -1, st_rd_len = 0, st_wr_idx = -1, st_wr_len = 0;
    int          rd_idx = 0, wr_idx = 0, stall_cnt = 0, cyc = 0;
    logic        rdv_q = 1'b0;
    logic [31:0] rdata_q = '0;
    logic [31:0] rd_addrs [$];

    function automatic logic [31:0] init_word(input int i);
        if (i < 4) return 32'h1111_1111 * (i + 1);
        return 32'hA500_0000 | i;
    endfunction

    always_comb begin
        avm_waitrequest = 1'b0;
        if (avm_read && rd_idx == st_rd_idx && stall_cnt < st_rd_len) avm_waitrequest = 1'b1;
        if (avm_write && wr_idx == st_wr_idx && stall_cnt < st_wr_len) avm_waitrequest = 1'b1;
    end

    always_comb begin
        if (zero_lat) begin
            avm_readdatavalid = avm_read && !avm_waitrequest;
            avm_readdata      = mem[avm_address[7:2]];
        end else begin
            avm_readdatavalid = rdv_q;
            avm_readdata      = rdata_q;
        end
    end

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        stall_cnt <= avm_waitrequest ? stall_cnt + 1 : 0;
        rdv_q     <= !zero_lat && avm_read && !avm_waitrequest;
        rdata_q   <= mem[avm_address[7:2]];
        if (avm_read && !avm_waitrequest) begin
            rd_idx <= rd_idx + 1;
            rd_addrs.push_back(avm_address);
        end
        if (reinit) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (avm_write && !avm_waitrequest) begin
            wr_idx <= wr_idx + 1;
            mem[avm_address[7:2]] <= avm_writedata;
        end
    end

    // ---------------- bus monitor ----------------
    int          both_cnt = 0, done_cnt = 0, rd_asrt = 0, wr_asrt = 0, stall_bad = 0, stall_cyc = 0;
    logic        hold_v = 1'b0;
    logic [31:0] h_addr = '0, h_wdata = '0;
    logic        h_rd = 1'b0, h_wr = 1'b0;

    always @(negedge clk) begin
        if (avm_read && avm_write) both_cnt <= both_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (avm_read) rd_asrt <= rd_asrt + 1;
        if (avm_write) wr_asrt <= wr_asrt + 1;
        if (hold_v && (avm_address !== h_addr || avm_read !== h_rd ||
                       avm_write !== h_wr || avm_writedata !== h_wdata))
            stall_bad <= stall_bad + 1;
        hold_v  <= avm_waitrequest && (avm_read || avm_write);
        if (avm_waitrequest && (avm_read || avm_write)) stall_cyc <= stall_cyc + 1;
        h_addr  <= avm_address;
        h_wdata <= avm_writedata;
        h_rd    <= avm_read;
        h_wr    <= avm_write;
    end

    // ---------------- checking helpers ----------------
    int total = 0, bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic reload();
        @(negedge clk) reinit = 1'b1;
        @(negedge clk) reinit = 1'b0;
        for (int i = 0; i < 64; i++) exp_mem[i] = init_word(i);
    endtask

    task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [5:0] si, di;
        si = s[7:2];
        di = d[7:2];
        for (int k = 0; k < n; k++) begin
            exp_mem[di] = exp_mem[si];
            si = si + 6'd1;
            di = di + 6'd1;
        end
    endtask

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) n++;
        return n;
    endfunction

    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                       input int glitch_at, input bit glitch_fin,
                       output int done_off, output int busy_cyc, output logic busy_after);
        int t0;
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
        t0 = cyc;
        done_off = -1;
        busy_cyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start = (i == glitch_at);
            if (start) begin src_addr = 32'h20; dst_addr = 32'h40; len = 16'd3; end
            if (busy) busy_cyc++;
            if (done) begin
                done_off = cyc - t0;
                if (glitch_fin) begin
                    start = 1'b1; src_addr = 32'h20; dst_addr = 32'h40; len = 16'd3;
                end
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
        busy_after = busy;
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        int          exp_done;
        int          exp_busy;
        logic [31:0] exp_csum;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int   d_off, b_cyc, rb, wb, db, sb, scb, ab, bb, rab, wab;
        logic b_after;
        bit   found;

        vecs[0] = '{32'h0000_0000, 32'h0000_0010, 16'd4, 13, 13, 32'h4444_4444};
        vecs[1] = '{32'h0000_0020, 32'h0000_0040, 16'd1, 4, 4, 32'hA500_0008};
        vecs[2] = '{32'h0000_0000, 32'h0000_0008, 16'd3, 10, 10, 32'h2222_2222};
        vecs[3] = '{32'h0000_0004, 32'h0000_0100, 16'd0, 1, 1, 32'h0000_0000};

        reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        reload();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_read", avm_read, 0);
        check("rst_write", avm_write, 0);
        check("rst_addr", avm_address, 0);
        check("rst_wdata", avm_writedata, 0);
        check("byteenable", avm_byteenable, 4'hF);
`ifdef AVM_WORD_COPIER_CHECKSUM_EN
        check("rst_csum", checksum, 0);
`endif
        reset_n = 1'b1;

        // table-driven transfers, no-wait slave with read latency 1
        for (int v = 0; v < 4; v++) begin
            reload();
            model_copy(vecs[v].src, vecs[v].dst, int'(vecs[v].len));
            rb = rd_idx; wb = wr_idx; db = done_cnt; bb = both_cnt; rab = rd_asrt; wab = wr_asrt;
            run(vecs[v].src, vecs[v].dst, vecs[v].len, -1, 1'b0, d_off, b_cyc, b_after);
            check($sformatf("v%0d_done_off", v), d_off, vecs[v].exp_done);
            check($sformatf("v%0d_busy_cyc", v), b_cyc, vecs[v].exp_busy);
            check($sformatf("v%0d_busy_after", v), b_after, 0);
            check($sformatf("v%0d_mem_diffs", v), mem_diffs(), 0);
            check($sformatf("v%0d_reads", v), rd_idx - rb, vecs[v].len);
            check($sformatf("v%0d_writes", v), wr_idx - wb, vecs[v].len);
            check($sformatf("v%0d_read_cycles", v), rd_asrt - rab, vecs[v].len);
            check($sformatf("v%0d_write_cycles", v), wr_asrt - wab, vecs[v].len);
            check($sformatf("v%0d_done_pulses", v), done_cnt - db, 1);
            check($sformatf("v%0d_rd_wr_overlap", v), both_cnt - bb, 0);
`ifdef AVM_WORD_COPIER_CHECKSUM_EN
            check($sformatf("v%0d_checksum", v), checksum, vecs[v].exp_csum);
`endif
        end

        // stalls: 3 cycles on the second read, 2 on the third write
        reload();
        model_copy(32'h0, 32'h10, 4);
        sb = stall_bad; scb = stall_cyc;
        st_rd_idx = rd_idx + 1; st_rd_len = 3;
        st_wr_idx = wr_idx + 2; st_wr_len = 2;
        run(32'h0, 32'h10, 16'd4, -1, 1'b0, d_off, b_cyc, b_after);
        st_rd_idx = -1; st_wr_idx = -1;
        check("stall_done_off", d_off, 18);
        check("stall_cycles", stall_cyc - scb, 5);
        check("stall_unstable", stall_bad - sb, 0);
        check("stall_mem_diffs", mem_diffs(), 0);

        // start during busy and during FIN must be ignored
        reload();
        model_copy(32'h0, 32'h10, 2);
        wb = wr_idx; db = done_cnt;
        run(32'h0, 32'h10, 16'd2, 2, 1'b1, d_off, b_cyc, b_after);
        repeat (3) @(negedge clk);
        check("ign_done_off", d_off, 7);
        check("ign_busy_after", b_after, 0);
        check("ign_writes", wr_idx - wb, 2);
        check("ign_done_pulses", done_cnt - db, 1);
        check("ign_mem_diffs", mem_diffs(), 0);

        // zero-latency slave with source address wrap
        reload();
        zero_lat = 1'b1;
        model_copy(32'hFFFF_FFFC, 32'h50, 2);
        rb = rd_idx;
        run(32'hFFFF_FFFC, 32'h50, 16'd2, -1, 1'b0, d_off, b_cyc, b_after);
        zero_lat = 1'b0;
        check("zl_done_off", d_off, 5);
        check("zl_rd_addr0", rd_addrs[rb], 32'hFFFF_FFFC);
        check("zl_rd_addr1", rd_addrs[rb + 1], 32'h0000_0000);
        check("zl_mem_diffs", mem_diffs(), 0);

        // reset asserted during the write of word 2 of 4
        reload();
        wb = wr_idx;
        @(negedge clk);
        start = 1'b1; src_addr = 32'h0; dst_addr = 32'h10; len = 16'd4;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (avm_write && (wr_idx - wb) == 1) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check("rstmid_reached_wr2", found, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_write", avm_write, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_read", avm_read, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run(32'h20, 32'h30, 16'd1, -1, 1'b0, d_off, b_cyc, b_after);
        check("rstmid_new_done_off", d_off, 4);
        check("rstmid_new_word", mem[12], 32'hA500_0008);
        check("rstmid_word0_copied", mem[4], 32'h1111_1111);
`ifdef AVM_WORD_COPIER_CHECKSUM_EN
        check("rstmid_checksum", checksum, 32'hA500_0008);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
